// File: rtl/fpga_status_led_ctrl.sv
// Board-status LED controller: NUM_LEDS channels, each OFF/ON/BLINK/PWM or an exit-code
// indicator driven by one shared pulse-code FSM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no exit seen yet; EXIT channels show the heartbeat
// S_SOLID   | exit code 0 latched; exit LED held on
// S_PULSE_ON| exit LED on for one pulse unit
// S_PULSE_OFF| exit LED off for one unit between pulses
// S_GAP     | exit LED off for four units before the train repeats
module fpga_status_led_ctrl #(
  parameter int NUM_LEDS    = 4,
  parameter int CNT_WIDTH   = 27,
  parameter int PWM_WIDTH   = 8,
  parameter int PULSE_SHIFT = 22,
  parameter int IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [IDX_W-1:0]     cfg_idx_i,
  input  logic [2:0]           cfg_mode_i,
  input  logic [PWM_WIDTH-1:0] cfg_arg_i,
  input  logic                 exit_valid_i,
  input  logic [31:0]          exit_value_i,
  output logic [NUM_LEDS-1:0]  led_o,
  output logic                 exit_latched_o,
  output logic [31:0]          exit_code_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOLID, S_PULSE_ON, S_PULSE_OFF, S_GAP
  } state_t;

  localparam logic [2:0] M_ON    = 3'd1;
  localparam logic [2:0] M_BLINK = 3'd2;
  localparam logic [2:0] M_PWM   = 3'd3;
  localparam logic [2:0] M_EXIT  = 3'd4;

  localparam int TMR_W = PULSE_SHIFT + 2;
  localparam logic [TMR_W-1:0] UNIT_M1 = TMR_W'((1 << PULSE_SHIFT) - 1);
  localparam logic [TMR_W-1:0] GAP_M1  = TMR_W'((4 << PULSE_SHIFT) - 1);
  localparam logic [PWM_WIDTH-1:0] SEL_MAX = PWM_WIDTH'(CNT_WIDTH - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0]           mode_q [NUM_LEDS];
  logic [PWM_WIDTH-1:0] arg_q  [NUM_LEDS];
  state_t               state_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [3:0]           pulse_q;
  logic [3:0]           n_q;
  logic                 exit_fire;
  logic                 exit_led;
  logic [NUM_LEDS-1:0]  led_nxt;

  assign exit_fire = exit_valid_i & ~exit_latched_o;
  assign exit_led  = (state_q == S_SOLID) || (state_q == S_PULSE_ON);

  function automatic logic blink_bit(input logic [CNT_WIDTH-1:0] c,
                                     input logic [PWM_WIDTH-1:0] a);
    logic [PWM_WIDTH-1:0] sel;
    logic [CNT_WIDTH-1:0] sh;
    sel = (a > SEL_MAX) ? SEL_MAX : a;
    sh  = c >> sel;
    return sh[0];
  endfunction

  // Out-of-range indices never match any channel, so such writes drop out naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q          <= '0;
      exit_latched_o <= 1'b0;
      exit_code_o    <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= (i == 0) ? M_EXIT : 3'd0;
        arg_q[i]  <= '0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (cfg_we_i && (cfg_idx_i == IDX_W'(i))) begin
          mode_q[i] <= cfg_mode_i;
          arg_q[i]  <= cfg_arg_i;
        end
      end
      if (exit_fire) begin
        exit_latched_o <= 1'b1;
        exit_code_o    <= exit_value_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      pulse_q <= '0;
      n_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (exit_fire) begin
            n_q     <= (exit_value_i > 32'd15) ? 4'd15 : exit_value_i[3:0];
            pulse_q <= '0;
            tmr_q   <= UNIT_M1;
            state_q <= (exit_value_i == 32'd0) ? S_SOLID : S_PULSE_ON;
          end
        end
        S_SOLID: state_q <= S_SOLID;
        S_PULSE_ON: begin
          if (tmr_q == '0) begin
            pulse_q <= pulse_q + 4'd1;
            if ((pulse_q + 4'd1) == n_q) begin
              state_q <= S_GAP;
              tmr_q   <= GAP_M1;
            end else begin
              state_q <= S_PULSE_OFF;
              tmr_q   <= UNIT_M1;
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_PULSE_OFF: begin
          if (tmr_q == '0) begin
            state_q <= S_PULSE_ON;
            tmr_q   <= UNIT_M1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_GAP: begin
          if (tmr_q == '0) begin
            state_q <= S_PULSE_ON;
            pulse_q <= '0;
            tmr_q   <= UNIT_M1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode_q[i])
        M_ON:    led_nxt[i] = 1'b1;
        M_BLINK: led_nxt[i] = blink_bit(cnt_q, arg_q[i]);
        M_PWM:   led_nxt[i] = (cnt_q[PWM_WIDTH-1:0] < arg_q[i]);
        M_EXIT:  led_nxt[i] = exit_latched_o ? exit_led : cnt_q[CNT_WIDTH-1];
        default: led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) led_o <= '0;
    else         led_o <= led_nxt;
  end

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Directed and random checks of fpga_status_led_ctrl against a cycle-indexed
// arithmetic model of the LED patterns.
module tb_fpga_status_led_ctrl;
  localparam int NL   = 4;
  localparam int UNIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_we_i;
  logic [1:0]  cfg_idx_i;
  logic [2:0]  cfg_mode_i;
  logic [3:0]  cfg_arg_i;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic [3:0]  led_o;
  logic        exit_latched_o;
  logic [31:0] exit_code_o;

  int total = 0;
  int bad   = 0;

  int          m_e;
  int          m_mode [NL];
  int          m_arg  [NL];
  bit          m_lat;
  logic [31:0] m_code;
  int          m_lat_e;

  fpga_status_led_ctrl #(
    .NUM_LEDS(4), .CNT_WIDTH(8), .PWM_WIDTH(4), .PULSE_SHIFT(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_mode_i(cfg_mode_i), .cfg_arg_i(cfg_arg_i), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .led_o(led_o), .exit_latched_o(exit_latched_o),
    .exit_code_o(exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  // Exit pattern as a function of cycles since the latch edge.
  function automatic bit exit_led_m();
    int n, per, ph;
    if (m_code == 32'd0) return 1'b1;
    n   = (m_code > 32'd15) ? 15 : int'(m_code);
    per = (2 * n + 3) * UNIT;
    ph  = (m_e - m_lat_e) % per;
    if (ph < (2 * n - 1) * UNIT) return ((ph / UNIT) % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_leds();
    logic [3:0] r;
    int c, b;
    c = m_e % 256;
    r = '0;
    for (int ch = 0; ch < NL; ch++) begin
      case (m_mode[ch])
        1: r[ch] = 1'b1;
        2: begin
          b = (m_arg[ch] > 7) ? 7 : m_arg[ch];
          r[ch] = ((c / (1 << b)) % 2) == 1;
        end
        3: r[ch] = (c % 16) < m_arg[ch];
        4: r[ch] = m_lat ? exit_led_m() : (c >= 128);
        default: r[ch] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%0h expected=%0h", tag, m_e, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_e = 0;
    for (int i = 0; i < NL; i++) begin
      m_mode[i] = (i == 0) ? 4 : 0;
      m_arg[i]  = 0;
    end
    m_lat   = 1'b0;
    m_code  = '0;
    m_lat_e = 0;
  endtask

  task automatic step(input logic we, input logic [1:0] idx, input logic [2:0] md,
                      input logic [3:0] ag, input logic ev, input logic [31:0] val);
    logic [3:0] exp_led;
    cfg_we_i     = we;
    cfg_idx_i    = idx;
    cfg_mode_i   = md;
    cfg_arg_i    = ag;
    exit_valid_i = ev;
    exit_value_i = val;
    exp_led = model_leds();
    if (we) begin
      m_mode[idx] = int'(md);
      m_arg[idx]  = int'(ag);
    end
    if (ev && !m_lat) begin
      m_lat   = 1'b1;
      m_code  = val;
      m_lat_e = m_e + 1;
    end
    m_e++;
    @(posedge clk_i);
    #1;
    check("led", 32'(led_o), 32'(exp_led));
    check("latched", 32'(exit_latched_o), 32'(m_lat));
    check("code", exit_code_o, m_code);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    cfg_we_i     = 1'b0;
    exit_valid_i = 1'b0;
    #3;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rst_led", 32'(led_o), 32'd0);
    check("rst_latched", 32'(exit_latched_o), 32'd0);
    check("rst_code", exit_code_o, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    rst_ni       = 1'b0;
    cfg_we_i     = 1'b0;
    cfg_idx_i    = '0;
    cfg_mode_i   = '0;
    cfg_arg_i    = '0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    #1;
    model_reset();
    check("init_led", 32'(led_o), 32'd0);
    check("init_latched", 32'(exit_latched_o), 32'd0);
    check("init_code", exit_code_o, 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // heartbeat only
    idle(300);

    // blink / pwm / on channels
    step(1'b1, 2'd1, 3'd2, 4'd1, 1'b0, 32'd0);
    step(1'b1, 2'd2, 3'd3, 4'd4, 1'b0, 32'd0);
    step(1'b1, 2'd3, 3'd1, 4'd0, 1'b0, 32'd0);
    idle(40);

    // exit 3, then a later exit that must be ignored
    step(1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 32'd3);
    idle(80);
    step(1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 32'd7);
    idle(80);

    // exit 0 solid, then clamped code
    do_reset();
    idle(5);
    step(1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 32'd0);
    idle(50);
    do_reset();
    idle(7);
    step(1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 32'h100);
    idle(300);

    // ch2 switched to EXIT on the latch cycle
    do_reset();
    idle(3);
    step(1'b1, 2'd2, 3'd4, 4'd0, 1'b1, 32'd2);
    repeat (100) begin
      step(1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 32'd0);
      check("ch2_tracks_ch0", 32'(led_o[2]), 32'(led_o[0]));
    end

    // reset during the second pulse
    do_reset();
    idle(2);
    step(1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 32'd3);
    idle(10);
    check("second_pulse_on", 32'(led_o[0]), 32'd1);
    do_reset();
    idle(300);

    // random episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      repeat (400) begin
        case ($urandom_range(0, 3))
          0:       v = 32'd0;
          1:       v = 32'($urandom_range(1, 15));
          2:       v = 32'($urandom_range(16, 300));
          default: v = $urandom;
        endcase
        step($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             4'($urandom_range(0, 15)), $urandom_range(0, 79) == 0, v);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
